// File: rtl/mips_alu_pkg.sv
// Shared opcode/funct codes and the mul/div FSM encoding
// for the registered execute-stage ALU.
package mips_alu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } md_state_t;

    function automatic logic is_muldiv(input logic [5:0] fn);
        return (fn == FN_MULT) || (fn == FN_MULTU) ||
               (fn == FN_DIV)  || (fn == FN_DIVU);
    endfunction

endpackage

// File: rtl/mips_muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider on
// sign magnitudes, with a final sign-fix step before HI/LO.
module mips_muldiv_unit
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             idle,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    md_state_t state;
    md_state_t state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] ph;
    logic [WIDTH-1:0] pl;
    logic [WIDTH-1:0] dvs;
    logic             op_mul;
    logic             neg_lo;
    logic             neg_hi;

    logic             sgn;
    logic             is_div;
    logic             a_neg;
    logic             b_neg;
    logic             div_zero;
    logic             last;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   msum;
    logic [WIDTH:0]   dshift;
    logic [WIDTH:0]   ddiff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;

    assign sgn      = (funct == FN_MULT) || (funct == FN_DIV);
    assign is_div   = (funct == FN_DIV) || (funct == FN_DIVU);
    assign a_neg    = sgn && opa[WIDTH-1];
    assign b_neg    = sgn && opb[WIDTH-1];
    assign a_mag    = a_neg ? -opa : opa;
    assign b_mag    = b_neg ? -opb : opb;
    assign div_zero = is_div && (opb == '0);
    assign last     = (cnt == CNT_W'(WIDTH - 1));

    assign msum   = {1'b0, ph} + (pl[0] ? {1'b0, dvs} : '0);
    assign dshift = {ph, pl[WIDTH-1]};
    assign ddiff  = dshift - {1'b0, dvs};

    assign prod     = {ph, pl};
    assign prod_fix = neg_lo ? -prod : prod;

    assign res_hi = op_mul ? prod_fix[2*WIDTH-1:WIDTH]
                           : (neg_hi ? -ph : ph);
    assign res_lo = op_mul ? prod_fix[WIDTH-1:0]
                           : (neg_lo ? -pl : pl);

    assign idle = (state == ST_IDLE);
    assign busy = (state == ST_MUL) || (state == ST_DIV) ||
                  (state == ST_FIX);
    assign done = (state == ST_FIX);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: divide by zero bypasses the iteration
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    if (!is_div) begin
                        state_nxt = ST_MUL;
                    end else if (div_zero) begin
                        state_nxt = ST_FIX;
                    end else begin
                        state_nxt = ST_DIV;
                    end
                end
            end
            ST_MUL:  if (last) state_nxt = ST_FIX;
            ST_DIV:  if (last) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand latch and one iteration step per cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            ph     <= '0;
            pl     <= '0;
            dvs    <= '0;
            op_mul <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        cnt    <= '0;
                        dvs    <= b_mag;
                        op_mul <= !is_div;
                        if (div_zero) begin
                            ph     <= opa;
                            pl     <= '1;
                            neg_lo <= 1'b0;
                            neg_hi <= 1'b0;
                        end else begin
                            ph     <= '0;
                            pl     <= a_mag;
                            neg_lo <= a_neg ^ b_neg;
                            neg_hi <= a_neg;
                        end
                    end
                end
                ST_MUL: begin
                    cnt <= cnt + CNT_W'(1);
                    ph  <= msum[WIDTH:1];
                    pl  <= {msum[0], pl[WIDTH-1:1]};
                end
                ST_DIV: begin
                    cnt <= cnt + CNT_W'(1);
                    if (!ddiff[WIDTH]) begin
                        ph <= ddiff[WIDTH-1:0];
                        pl <= {pl[WIDTH-2:0], 1'b1};
                    end else begin
                        ph <= dshift[WIDTH-1:0];
                        pl <= {pl[WIDTH-2:0], 1'b0};
                    end
                end
                default: begin
                    cnt <= cnt;
                end
            endcase
        end
    end

endmodule

// File: rtl/mips_alu_seq.sv
// Registered execute-stage ALU: single-cycle R-type ops plus
// a handshaked iterative mul/div unit owning HI/LO.
module mips_alu_seq
    import mips_alu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MULDIV_EN = 1,
    parameter int CNT_W     = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] indataout1,
    input  logic [WIDTH-1:0] indataout2,
    input  logic [5:0]       inopcode,
    input  logic [5:0]       infunct,
    output logic [WIDTH-1:0] aluresult,
    output logic             rw,
    output logic             ovf,
    output logic             illegal,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam bit MD = (MULDIV_EN != 0);

    logic             fire;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] dif;
    logic             add_ovf;
    logic             sub_ovf;
    logic             lt_s;
    logic             lt_u;

    logic [WIDTH-1:0] res;
    logic             wr;
    logic             ov;
    logic             ill;
    logic             md_go;

    logic             md_idle;
    logic             md_busy;
    logic             md_done;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;

    assign a = indataout1;
    assign b = indataout2;

    assign sum = a + b;
    assign dif = a - b;

    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) &&
                     (sum[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) &&
                     (dif[WIDTH-1] != a[WIDTH-1]);

    assign lt_s = $signed(a) < $signed(b);
    assign lt_u = a < b;

    assign in_ready = md_idle;
    assign busy     = md_busy;
    assign fire     = in_valid && in_ready;

    // Decode: result, write strobe and flags for this op
    always_comb begin
        res   = '0;
        wr    = 1'b0;
        ov    = 1'b0;
        ill   = 1'b0;
        md_go = 1'b0;
        if (inopcode != OP_RTYPE) begin
            ill = 1'b1;
        end else begin
            unique case (1'b1)
                (infunct == FN_ADD): begin
                    res = sum;
                    ov  = add_ovf;
                    wr  = !add_ovf;
                end
                (infunct == FN_SUB): begin
                    res = dif;
                    ov  = sub_ovf;
                    wr  = !sub_ovf;
                end
                (infunct == FN_ADDU): begin
                    res = sum;
                    wr  = 1'b1;
                end
                (infunct == FN_SUBU): begin
                    res = dif;
                    wr  = 1'b1;
                end
                (infunct == FN_AND): begin
                    res = a & b;
                    wr  = 1'b1;
                end
                (infunct == FN_OR): begin
                    res = a | b;
                    wr  = 1'b1;
                end
                (infunct == FN_XOR): begin
                    res = a ^ b;
                    wr  = 1'b1;
                end
                (infunct == FN_NOR): begin
                    res = ~(a | b);
                    wr  = 1'b1;
                end
                (infunct == FN_SLT): begin
                    res[0] = lt_s;
                    wr     = 1'b1;
                end
                (infunct == FN_SLTU): begin
                    res[0] = lt_u;
                    wr     = 1'b1;
                end
                (MD && infunct == FN_MFHI): begin
                    res = hi;
                    wr  = 1'b1;
                end
                (MD && infunct == FN_MFLO): begin
                    res = lo;
                    wr  = 1'b1;
                end
                (MD && is_muldiv(infunct)): begin
                    md_go = 1'b1;
                end
                default: begin
                    ill = 1'b1;
                end
            endcase
        end
    end

    mips_muldiv_unit #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (fire && md_go),
        .funct  (infunct),
        .opa    (a),
        .opb    (b),
        .idle   (md_idle),
        .busy   (md_busy),
        .done   (md_done),
        .res_hi (md_hi),
        .res_lo (md_lo)
    );

    // Output registers; HI/LO load when the unit finishes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aluresult <= '0;
            rw        <= 1'b0;
            ovf       <= 1'b0;
            illegal   <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            rw      <= fire && wr;
            ovf     <= fire && ov;
            illegal <= fire && ill;
            if (fire && wr) begin
                aluresult <= res;
            end
            if (md_done) begin
                hi <= md_hi;
                lo <= md_lo;
            end
        end
    end

endmodule

// File: tb/tb_mips_alu_seq.sv
// Random and directed checks of mips_alu_seq against an
// arithmetic reference model; second instance at 16 bits, no mul/div.
module tb_mips_alu_seq;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] indataout1;
    logic [31:0] indataout2;
    logic [5:0]  inopcode;
    logic [5:0]  infunct;
    logic [31:0] aluresult;
    logic        rw;
    logic        ovf;
    logic        illegal;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        v16;
    logic        rdy16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic [5:0]  op16;
    logic [5:0]  fn16;
    logic [15:0] r16;
    logic        rw16;
    logic        ovf16;
    logic        ill16;
    logic        busy16;
    logic [15:0] hi16;
    logic [15:0] lo16;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mips_alu_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .indataout1 (indataout1),
        .indataout2 (indataout2),
        .inopcode   (inopcode),
        .infunct    (infunct),
        .aluresult  (aluresult),
        .rw         (rw),
        .ovf        (ovf),
        .illegal    (illegal),
        .busy       (busy),
        .hi         (hi),
        .lo         (lo)
    );

    mips_alu_seq #(.WIDTH(16), .MULDIV_EN(0)) dut16 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (v16),
        .in_ready   (rdy16),
        .indataout1 (a16),
        .indataout2 (b16),
        .inopcode   (op16),
        .infunct    (fn16),
        .aluresult  (r16),
        .rw         (rw16),
        .ovf        (ovf16),
        .illegal    (ill16),
        .busy       (busy16),
        .hi         (hi16),
        .lo         (lo16)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          occ;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] ph;
        logic [31:0] pl;
        logic [31:0] res;
        bit          rw;
        bit          ov;
        bit          il;
    } mstate_t;

    mstate_t m = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

    function automatic longint sx(input logic [31:0] v);
        return longint'($signed(v));
    endfunction

    function automatic mstate_t step(input mstate_t s, input bit rn,
            input bit v, input logic [5:0] op, input logic [5:0] fn,
            input logic [31:0] a, input logic [31:0] b);
        mstate_t n;
        bit rdy;
        longint sa, sb, t, u;
        logic [63:0] p;
        n = s;
        rdy = (s.occ == 0);
        n.rw = 0;
        n.ov = 0;
        n.il = 0;
        if (!rn) begin
            n.occ = 0;
            n.hi = 0;
            n.lo = 0;
            n.res = 0;
            return n;
        end
        if (s.occ > 0) begin
            n.occ = s.occ - 1;
            if (n.occ == 1) begin
                n.hi = s.ph;
                n.lo = s.pl;
            end
        end
        if (!(v && rdy)) return n;
        if (op != 6'b000000) begin
            n.il = 1;
            return n;
        end
        sa = sx(a);
        sb = sx(b);
        case (fn)
            F_ADD, F_SUB: begin
                t = (fn == F_ADD) ? sa + sb : sa - sb;
                if (t != sx(t[31:0])) n.ov = 1;
                else begin
                    n.res = t[31:0];
                    n.rw = 1;
                end
            end
            F_ADDU: begin n.res = a + b; n.rw = 1; end
            F_SUBU: begin n.res = a - b; n.rw = 1; end
            F_AND:  begin n.res = a & b; n.rw = 1; end
            F_OR:   begin n.res = a | b; n.rw = 1; end
            F_XOR:  begin n.res = a ^ b; n.rw = 1; end
            F_NOR:  begin n.res = ~(a | b); n.rw = 1; end
            F_SLT:  begin n.res = (sa < sb) ? 1 : 0; n.rw = 1; end
            F_SLTU: begin n.res = (a < b) ? 1 : 0; n.rw = 1; end
            F_MFHI: begin n.res = s.hi; n.rw = 1; end
            F_MFLO: begin n.res = s.lo; n.rw = 1; end
            F_MULT: begin
                t = sa * sb;
                p = t;
                n.ph = p[63:32];
                n.pl = p[31:0];
                n.occ = 34;
            end
            F_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                n.ph = p[63:32];
                n.pl = p[31:0];
                n.occ = 34;
            end
            F_DIV, F_DIVU: begin
                if (b == 0) begin
                    n.ph = a;
                    n.pl = 32'hFFFFFFFF;
                    n.occ = 2;
                end else if (fn == F_DIV) begin
                    t = sa / sb;
                    u = sa % sb;
                    n.pl = t[31:0];
                    n.ph = u[31:0];
                    n.occ = 34;
                end else begin
                    n.pl = a / b;
                    n.ph = a % b;
                    n.occ = 34;
                end
            end
            default: n.il = 1;
        endcase
        return n;
    endfunction

    always @(posedge clk) begin
        m <= step(m, rst_n, in_valid, inopcode, infunct,
                  indataout1, indataout2);
    end

    // every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_rw", 32'(rw), 32'(m.rw));
            chk("cyc_ovf", 32'(ovf), 32'(m.ov));
            chk("cyc_illegal", 32'(illegal), 32'(m.il));
            chk("cyc_result", aluresult, m.res);
            chk("cyc_hi", hi, m.hi);
            chk("cyc_lo", lo, m.lo);
            chk("cyc_busy", 32'(busy), 32'(m.occ > 1));
            chk("cyc_ready", 32'(in_ready), 32'(m.occ == 0));
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b,
                         output int waited);
        bit took;
        took = 0;
        waited = 0;
        inopcode = op;
        infunct = fn;
        indataout1 = a;
        indataout2 = b;
        in_valid = 1;
        for (int k = 0; k < 100 && !took; k++) begin
            took = in_ready;
            if (!took) waited++;
            @(negedge clk);
            #1;
        end
        if (!took) chk("accept_timeout", 0, 1);
        in_valid = 0;
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 100 && !in_ready; k++) begin
            @(negedge clk);
            #1;
        end
        chk("ready_timeout", 32'(in_ready), 1);
    endtask

    task automatic op16_go(input logic [5:0] op, input logic [5:0] fn,
                           input logic [15:0] a, input logic [15:0] b);
        op16 = op;
        fn16 = fn;
        a16 = a;
        b16 = b;
        v16 = 1;
        @(negedge clk);
        #1;
        v16 = 0;
    endtask

    function automatic logic [31:0] rop();
        case ($urandom_range(0, 7))
            0: return 32'h00000000;
            1: return 32'h00000001;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            5: return 32'($urandom_range(0, 20)) - 32'd10;
            default: return $urandom();
        endcase
    endfunction

    logic [5:0] ftab [16] = '{F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND,
        F_OR, F_XOR, F_NOR, F_SLT, F_SLTU, F_MFHI, F_MFLO, F_MULT,
        F_MULTU, F_DIV, F_DIVU};

    initial begin
        int w;
        int r;
        logic [5:0] op, fn;
        rst_n = 0;
        in_valid = 0;
        inopcode = 0;
        infunct = 0;
        indataout1 = 0;
        indataout2 = 0;
        v16 = 0;
        op16 = 0;
        fn16 = 0;
        a16 = 0;
        b16 = 0;

        // reset with a valid op presented
        @(negedge clk);
        #1;
        in_valid = 1;
        infunct = F_ADD;
        indataout1 = 1;
        indataout2 = 2;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rw", 32'(rw), 0);
        chk("rst_result", aluresult, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk_en = 1;
        in_valid = 0;
        rst_n = 1;
        @(negedge clk);
        #1;

        // back-to-back add (ovf), addu, sub
        issue(0, F_ADD, 32'h7FFFFFFF, 32'h1, w);
        chk("add_ovf", 32'(ovf), 1);
        chk("add_rw", 32'(rw), 0);
        issue(0, F_ADDU, 32'h7FFFFFFF, 32'h1, w);
        chk("addu_res", aluresult, 32'h80000000);
        chk("addu_rw", 32'(rw), 1);
        issue(0, F_SUB, 32'd5, 32'd7, w);
        chk("sub_res", aluresult, 32'hFFFFFFFE);
        chk("sub_rw", 32'(rw), 1);

        issue(0, F_SLT, 32'hFFFFFFFF, 32'h1, w);
        chk("slt", aluresult, 32'h1);
        issue(0, F_SLTU, 32'hFFFFFFFF, 32'h1, w);
        chk("sltu", aluresult, 32'h0);
        issue(0, F_NOR, 32'h0, 32'h0, w);
        chk("nor", aluresult, 32'hFFFFFFFF);
        issue(0, F_XOR, 32'hF0F0, 32'hFF00, w);
        chk("xor", aluresult, 32'h0FF0);

        // mult -3*7 then a stalled mflo
        issue(0, F_MULT, 32'hFFFFFFFD, 32'd7, w);
        issue(0, F_MFLO, 32'h0, 32'h0, w);
        chk("mult_stall", w, 34);
        chk("mflo_res", aluresult, 32'hFFFFFFEB);
        chk("mflo_rw", 32'(rw), 1);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFEB);

        issue(0, F_DIV, 32'hFFFFFFF9, 32'd2, w);
        wait_ready();
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);
        issue(0, F_DIV, 32'h80000000, 32'hFFFFFFFF, w);
        wait_ready();
        chk("divmin_lo", lo, 32'h80000000);
        chk("divmin_hi", hi, 32'h0);
        issue(0, F_DIVU, 32'd7, 32'd0, w);
        wait_ready();
        chk("div0_hi", hi, 32'd7);
        chk("div0_lo", lo, 32'hFFFFFFFF);

        // abort mid-mult
        issue(0, F_MULTU, 32'h12345, 32'h6789, w);
        repeat (9) @(negedge clk);
        #1;
        rst_n = 0;
        @(negedge clk);
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        chk("abort_ready", 32'(in_ready), 1);
        rst_n = 1;
        @(negedge clk);
        #1;

        issue(6'b100011, F_ADD, 32'd1, 32'd1, w);
        chk("badop_ill", 32'(illegal), 1);
        chk("badop_rw", 32'(rw), 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            repeat ($urandom_range(0, 2)) begin
                inopcode = 6'($urandom());
                infunct = 6'($urandom());
                indataout1 = $urandom();
                indataout2 = $urandom();
                @(negedge clk);
                #1;
            end
            r = $urandom_range(0, 19);
            op = 6'b000000;
            if (r < 16) fn = ftab[r];
            else fn = 6'($urandom());
            if (r == 16 || r == 17) op = 6'($urandom_range(1, 63));
            issue(op, fn, rop(), rop(), w);
        end
        wait_ready();

        // 16-bit instance without mul/div
        op16_go(0, F_MULT, 16'd3, 16'd7);
        chk("w16_mult_ill", 32'(ill16), 1);
        chk("w16_mult_rw", 32'(rw16), 0);
        chk("w16_busy", 32'(busy16), 0);
        chk("w16_ready", 32'(rdy16), 1);
        op16_go(0, F_ADD, 16'h7FFF, 16'h1);
        chk("w16_add_ovf", 32'(ovf16), 1);
        chk("w16_ill_clr", 32'(ill16), 0);
        op16_go(0, F_ADDU, 16'h7FFF, 16'h1);
        chk("w16_addu", 32'(r16), 32'h8000);
        chk("w16_addu_rw", 32'(rw16), 1);
        op16_go(0, F_MFHI, 16'h0, 16'h0);
        chk("w16_mfhi_ill", 32'(ill16), 1);
        op16_go(0, F_SLTU, 16'hFFFF, 16'h1);
        chk("w16_sltu", 32'(r16), 0);
        chk("w16_sltu_rw", 32'(rw16), 1);

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
